pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline. It covers operand
// forwarding, load-use stall detection, a multi-cycle MDU sequencer,
// branch flush and an external freeze. It also keeps a saturating count of
// the cycles lost to hazard stalls.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_LAT = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic        d_mdu,
  input  logic [4:0]  e_rd,
  input  logic        e_wreg,
  input  logic        e_m2reg,
  input  logic [4:0]  m_rd,
  input  logic        m_wreg,
  input  logic        m_m2reg,
  input  logic        br_taken,
  input  logic        ext_hold,
  output logic        wpcir,
  output logic        flush_ir,
  output logic        bubble_de,
  output logic        pipe_en,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        mdu_go,
  output logic        mdu_done,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic exMatchRs, exMatchRt, memMatchRs, memMatchRt;
  logic loadUse, mduStall, hazard, mduStart;

  // Register r is a live producer only when it is non-zero and the stage actually writes it
  always_comb begin
    exMatchRs  = (d_rs != 5'd0) && (d_rs == e_rd) && e_wreg;
    exMatchRt  = (d_rt != 5'd0) && (d_rt == e_rd) && e_wreg;
    memMatchRs = (d_rs != 5'd0) && (d_rs == m_rd) && m_wreg;
    memMatchRt = (d_rt != 5'd0) && (d_rt == m_rd) && m_wreg;
    loadUse    = e_m2reg && ((d_use_rs && exMatchRs) || (d_use_rt && exMatchRt));
  end

  // Operand bypass selects; EX wins over MEM, and a load in EX cannot forward yet
  always_comb begin
    fwda = 2'b00;
    fwdb = 2'b00;
    if (exMatchRs && !e_m2reg) fwda = 2'b01;
    else if (memMatchRs)       fwda = m_m2reg ? 2'b11 : 2'b10;
    if (exMatchRt && !e_m2reg) fwdb = 2'b01;
    else if (memMatchRt)       fwdb = m_m2reg ? 2'b11 : 2'b10;
  end

  // MDU sequencer next state, stall counter update and all pipeline control outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    wpcir       = 1'b1;
    pipe_en     = 1'b1;
    bubble_de   = 1'b0;
    flush_ir    = 1'b0;
    mdu_go      = 1'b0;
    mdu_done    = 1'b0;

    mduStart = (state_q == IDLE) && d_mdu && !loadUse;
    mduStall = mduStart || (state_q == BUSY);
    hazard   = loadUse || mduStall;

    if (!ext_hold) begin
      unique case (state_q)
        IDLE: if (mduStart) begin
          state_d = BUSY;
          cnt_d   = 4'(MDU_LAT - 1);
        end
        BUSY: if (cnt_q == 4'd0) state_d = DONE;
              else               cnt_d   = cnt_q - 4'd1;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (hazard && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    if (clrn) begin
      wpcir   = 1'b1;
      pipe_en = 1'b1;
    end else if (ext_hold) begin
      wpcir    = 1'b0;
      pipe_en  = 1'b0;
      mdu_done = (state_q == DONE);
    end else begin
      mdu_go   = mduStart;
      mdu_done = (state_q == DONE);
      if (hazard) begin
        wpcir     = 1'b0;
        bubble_de = 1'b1;
      end else begin
        flush_ir  = br_taken;
      end
    end
  end

  // State registers; reset aborts any MDU operation in flight without signalling done
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the stimulus process queues a
// hand-computed expectation for every cycle, and a monitor on the falling
// edge pops and compares it against the DUT outputs.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       clrn;
    logic [4:0] dRs;
    logic [4:0] dRt;
    logic       useRs;
    logic       useRt;
    logic       mdu;
    logic [4:0] eRd;
    logic       eWreg;
    logic       eM2reg;
    logic [4:0] mRd;
    logic       mWreg;
    logic       mM2reg;
    logic       br;
    logic       hold;
  } stim_t;

  typedef struct packed {
    logic [15:0] step;
    logic        wpcir;
    logic        flushIr;
    logic        bubbleDe;
    logic        pipeEn;
    logic [1:0]  fwda;
    logic [1:0]  fwdb;
    logic        go;
    logic        done;
    logic [15:0] stallCnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  dRs, dRt, eRd, mRd;
  logic        dUseRs, dUseRt, dMdu, eWreg, eM2reg, mWreg, mM2reg, brTaken, extHold;
  logic        wpcir, flushIr, bubbleDe, pipeEn, mduGo, mduDone;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stallCnt;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;

  pipe_hazard_ctrl #(.MDU_LAT(8)) dut (
    .clk(clk), .clrn(clrn),
    .d_rs(dRs), .d_rt(dRt), .d_use_rs(dUseRs), .d_use_rt(dUseRt), .d_mdu(dMdu),
    .e_rd(eRd), .e_wreg(eWreg), .e_m2reg(eM2reg),
    .m_rd(mRd), .m_wreg(mWreg), .m_m2reg(mM2reg),
    .br_taken(brTaken), .ext_hold(extHold),
    .wpcir(wpcir), .flush_ir(flushIr), .bubble_de(bubbleDe), .pipe_en(pipeEn),
    .fwda(fwda), .fwdb(fwdb), .mdu_go(mduGo), .mdu_done(mduDone), .stall_cnt(stallCnt)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  function automatic exp_t expRun(input logic [15:0] sc);
    exp_t e;
    e = '0;
    e.wpcir = 1'b1; e.pipeEn = 1'b1; e.stallCnt = sc;
    return e;
  endfunction

  function automatic exp_t expStall(input logic [15:0] sc);
    exp_t e;
    e = expRun(sc);
    e.wpcir = 1'b0; e.bubbleDe = 1'b1;
    return e;
  endfunction

  function automatic exp_t expHold(input logic [15:0] sc);
    exp_t e;
    e = '0;
    e.stallCnt = sc;
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    clrn = s.clrn; dRs = s.dRs; dRt = s.dRt; dUseRs = s.useRs; dUseRt = s.useRt;
    dMdu = s.mdu; eRd = s.eRd; eWreg = s.eWreg; eM2reg = s.eM2reg;
    mRd = s.mRd; mWreg = s.mWreg; mM2reg = s.mM2reg; brTaken = s.br; extHold = s.hold;
    stepNo++;
    e.step = 16'(stepNo);
    expQ.push_back(e);
  endtask

  task automatic cmpField(input string name, input logic [15:0] step,
                          input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL step %0d %s: got %0h, expected %0h", step, name, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField("wpcir",     e.step, 16'(wpcir),    16'(e.wpcir));
    cmpField("flush_ir",  e.step, 16'(flushIr),  16'(e.flushIr));
    cmpField("bubble_de", e.step, 16'(bubbleDe), 16'(e.bubbleDe));
    cmpField("pipe_en",   e.step, 16'(pipeEn),   16'(e.pipeEn));
    cmpField("fwda",      e.step, 16'(fwda),     16'(e.fwda));
    cmpField("fwdb",      e.step, 16'(fwdb),     16'(e.fwdb));
    cmpField("mdu_go",    e.step, 16'(mduGo),    16'(e.go));
    cmpField("mdu_done",  e.step, 16'(mduDone),  16'(e.done));
    cmpField("stall_cnt", e.step, stallCnt,      e.stallCnt);
  endtask

  // Monitor: one queued expectation is checked per falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    stim_t s;
    exp_t  e;
    clrn = 1'b1; dRs = '0; dRt = '0; dUseRs = 0; dUseRt = 0; dMdu = 0;
    eRd = '0; eWreg = 0; eM2reg = 0; mRd = '0; mWreg = 0; mM2reg = 0;
    brTaken = 0; extHold = 0;

    // Reset with an MDU request present: outputs forced to the run state
    s = '0; s.clrn = 1; s.mdu = 1;
    applyStimulus(s, expRun(0));

    // Load-use on rs stalls one cycle
    s = '0; s.eRd = 5; s.eWreg = 1; s.eM2reg = 1; s.dRs = 5; s.useRs = 1;
    applyStimulus(s, expStall(0));
    // Load now in MEM: forward loaded data
    s = '0; s.mRd = 5; s.mWreg = 1; s.mM2reg = 1; s.dRs = 5; s.useRs = 1;
    e = expRun(1); e.fwda = 2'b11; applyStimulus(s, e);

    // EX beats MEM on rt
    s = '0; s.eRd = 7; s.mRd = 7; s.eWreg = 1; s.mWreg = 1; s.dRt = 7; s.useRt = 1;
    e = expRun(1); e.fwdb = 2'b01; applyStimulus(s, e);
    // Register zero never matches
    s = '0; s.eWreg = 1; s.mWreg = 1; s.useRt = 1;
    applyStimulus(s, expRun(1));
    // MEM ALU forward on both operands; EX with wreg=0 is ignored
    s = '0; s.eRd = 7; s.mRd = 7; s.mWreg = 1; s.dRs = 7; s.dRt = 7;
    e = expRun(1); e.fwda = 2'b10; e.fwdb = 2'b10; applyStimulus(s, e);

    // Branch during load-use stall is suppressed
    s = '0; s.br = 1; s.eRd = 3; s.eWreg = 1; s.eM2reg = 1; s.dRt = 3; s.useRt = 1;
    applyStimulus(s, expStall(1));
    // Stall released: branch flushes
    s = '0; s.br = 1;
    e = expRun(2); e.flushIr = 1; applyStimulus(s, e);
    // Load in EX matching rt but rt unused: no stall and no forward
    s = '0; s.eRd = 3; s.eWreg = 1; s.eM2reg = 1; s.dRt = 3;
    applyStimulus(s, expRun(2));

    // Reset clears stall count before the MDU run
    s = '0; s.clrn = 1;
    applyStimulus(s, expRun(2));

    // Full MDU run, request held
    s = '0; s.mdu = 1;
    for (int k = 0; k <= 9; k++) begin
      if (k == 0)      begin e = expStall(0); e.go = 1; end
      else if (k <= 8) e = expStall(16'(k));
      else             begin e = expRun(9); e.done = 1; end
      applyStimulus(s, e);
    end
    s.mdu = 0;
    applyStimulus(s, expRun(9));

    // MDU run with a three-cycle freeze mid-BUSY, run to completion
    s = '0; s.mdu = 1;
    for (int c = 0; c <= 12; c++) begin
      s.hold = (c >= 3 && c <= 5);
      if (c == 0)       begin e = expStall(9); e.go = 1; end
      else if (c <= 2)  e = expStall(16'(9 + c));
      else if (c <= 5)  e = expHold(12);
      else if (c <= 11) e = expStall(16'(12 + c - 6));
      else              begin e = expRun(18); e.done = 1; end
      applyStimulus(s, e);
    end
    s = '0;
    applyStimulus(s, expRun(18));

    // MDU run frozen, then aborted by reset: no done afterwards
    s = '0; s.mdu = 1;
    e = expStall(18); e.go = 1; applyStimulus(s, e);
    applyStimulus(s, expStall(19));
    s.hold = 1;
    for (int c = 0; c < 3; c++) applyStimulus(s, expHold(20));
    s.hold = 0;
    applyStimulus(s, expStall(20));
    s = '0; s.clrn = 1;
    applyStimulus(s, expRun(21));
    s = '0;
    for (int c = 0; c < 3; c++) applyStimulus(s, expRun(0));

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
